main_mem_arbiter: RTL and testbench

Two-requester arbiter in front of the single main-memory port. Port 0 serves the cache controller's line-refill and write-through traffic; port 1 serves the MMU page-table walker. The block latches single-cycle request pulses and grants one requester at a time. It issues exactly one memory transaction per grant and returns the registered response to the granted requester only.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_req_slot.sv | 66 ++++++
 rtl/main_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_main_mem_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the main-memory arbiter
package mem_arb_pkg;

  // Defaults shared with the cache controller.
  localparam int ADDR_W  = 32;
  localparam int WDATA_W = 32;
  localparam int LINE_W  = 512;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } op_t;

endpackage

// File: rtl/arb_req_slot.sv
// rtl/arb_req_slot.sv - per-port request capture slot with pending flag and protocol-error detection
module arb_req_slot #(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_req_i,
  input  logic               write_req_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [WDATA_W-1:0] wdata_i,
  input  logic               clear_i,
  output logic               pending_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [WDATA_W-1:0] wdata_o,
  output logic               write_o,
  output logic               err_o
);
  import mem_arb_pkg::*;

  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] wdata_q;
  op_t                op_q;
  logic               both_req;
  logic               any_req;
  logic               accept;

  // A slot frees up at the end of its response cycle, so a pulse arriving
  // alongside clear_i is a legal back-to-back request, not a collision.
  always_comb begin
    both_req  = read_req_i & write_req_i;
    any_req   = read_req_i | write_req_i;
    accept    = any_req & ~both_req & (~pending_q | clear_i);
    err_o     = both_req | (any_req & pending_q & ~clear_i);
    pending_d = pending_q;
    if (accept) begin
      pending_d = 1'b1;
    end else if (clear_i) begin
      pending_d = 1'b0;
    end
  end

  // Capture the request fields only when the request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      op_q      <= OP_READ;
    end else begin
      pending_q <= pending_d;
      if (accept) begin
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        op_q    <= write_req_i ? OP_WRITE : OP_READ;
      end
    end
  end

  assign pending_o = pending_q;
  assign addr_o    = addr_q;
  assign wdata_o   = wdata_q;
  assign write_o   = (op_q == OP_WRITE);

endmodule

// File: rtl/main_mem_arbiter.sv
// rtl/main_mem_arbiter.sv - two-port main-memory arbiter (cache port 0, page walker port 1); ARB_RR_EN selects round-robin
module main_mem_arbiter #(
  parameter int ADDR_W  = mem_arb_pkg::ADDR_W,
  parameter int WDATA_W = mem_arb_pkg::WDATA_W,
  parameter int LINE_W  = mem_arb_pkg::LINE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  r0_addr,
  input  logic [WDATA_W-1:0] r0_wdata,
  input  logic               r0_read_req,
  input  logic               r0_write_req,
  output logic [LINE_W-1:0]  r0_rdata,
  output logic               r0_ready,
  input  logic [ADDR_W-1:0]  r1_addr,
  input  logic [WDATA_W-1:0] r1_wdata,
  input  logic               r1_read_req,
  input  logic               r1_write_req,
  output logic [LINE_W-1:0]  r1_rdata,
  output logic               r1_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  output logic               mem_read_req,
  output logic               mem_write_req,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               proto_err
);
  import mem_arb_pkg::*;

  arb_state_t         state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               proto_err_q;
  logic [LINE_W-1:0]  rdata0_q, rdata1_q;
  logic               winner;
  logic               rdata_we;
  logic               clear0, clear1;

  logic [1:0]         pending;
  logic [ADDR_W-1:0]  slot0_addr, slot1_addr, sel_addr;
  logic [WDATA_W-1:0] slot0_wdata, slot1_wdata, sel_wdata;
  logic               slot0_write, slot1_write, sel_write;
  logic               err0, err1;

  arb_req_slot #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W)) u_slot0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_req_i  (r0_read_req),
    .write_req_i (r0_write_req),
    .addr_i      (r0_addr),
    .wdata_i     (r0_wdata),
    .clear_i     (clear0),
    .pending_o   (pending[0]),
    .addr_o      (slot0_addr),
    .wdata_o     (slot0_wdata),
    .write_o     (slot0_write),
    .err_o       (err0)
  );

  arb_req_slot #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W)) u_slot1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .read_req_i  (r1_read_req),
    .write_req_i (r1_write_req),
    .addr_i      (r1_addr),
    .wdata_i     (r1_wdata),
    .clear_i     (clear1),
    .pending_o   (pending[1]),
    .addr_o      (slot1_addr),
    .wdata_o     (slot1_wdata),
    .write_o     (slot1_write),
    .err_o       (err1)
  );

  assign sel_addr  = gnt_q ? slot1_addr  : slot0_addr;
  assign sel_wdata = gnt_q ? slot1_wdata : slot0_wdata;
  assign sel_write = gnt_q ? slot1_write : slot0_write;

`ifdef ARB_RR_EN
  logic rr_ptr_q;

  // Preferred port flips to the one not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else if (state_q == RESP) begin
      rr_ptr_q <= ~gnt_q;
    end
  end

  assign winner = (pending == 2'b11) ? rr_ptr_q : pending[1];
`else
  // Page walker always wins a tie; otherwise the only pending port wins.
  assign winner = pending[1];
`endif

  // Next-state and output decode; memory signals are only driven in ISSUE/WAIT.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    r0_ready      = 1'b0;
    r1_ready      = 1'b0;
    clear0        = 1'b0;
    clear1        = 1'b0;
    rdata_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending != 2'b00) begin
          gnt_d   = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_addr      = sel_addr;
        mem_wdata     = sel_wdata;
        mem_read_req  = ~sel_write;
        mem_write_req = sel_write;
        state_d       = WAIT;
      end
      WAIT: begin
        mem_addr  = sel_addr;
        mem_wdata = sel_wdata;
        if (mem_ready) begin
          rdata_we = ~sel_write;
          state_d  = RESP;
        end
      end
      RESP: begin
        r0_ready = ~gnt_q;
        r1_ready = gnt_q;
        clear0   = ~gnt_q;
        clear1   = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, grant and sticky protocol-error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      proto_err_q <= proto_err_q | err0 | err1;
    end
  end

  // Response lines hold until the next read completion for the same port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (rdata_we) begin
      if (gnt_q) begin
        rdata1_q <= mem_rdata;
      end else begin
        rdata0_q <= mem_rdata;
      end
    end
  end

  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;
  assign busy      = (state_q != IDLE) || (pending != 2'b00);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb/tb_main_mem_arbiter.sv - scoreboard testbench for main_mem_arbiter
module tb_main_mem_arbiter;

  localparam int MEM_LAT = 3;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic         port;
    logic [511:0] rdata;
  } resp_exp_t;

  logic         clk;
  logic         rst_n;
  logic [31:0]  r0_addr, r1_addr, r0_wdata, r1_wdata;
  logic         r0_read_req, r0_write_req, r1_read_req, r1_write_req;
  logic [511:0] r0_rdata, r1_rdata;
  logic         r0_ready, r1_ready;
  logic [31:0]  mem_addr, mem_wdata;
  logic         mem_read_req, mem_write_req;
  logic [511:0] mem_rdata;
  logic         mem_ready;
  logic         busy, proto_err;

  int checks = 0;
  int errors = 0;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];

  logic         use_fixed;
  logic [511:0] fixed_line;
  logic         rr_model;
  int           resp_cnt;
  logic [31:0]  resp_addr;

  main_mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .r0_addr       (r0_addr),
    .r0_wdata      (r0_wdata),
    .r0_read_req   (r0_read_req),
    .r0_write_req  (r0_write_req),
    .r0_rdata      (r0_rdata),
    .r0_ready      (r0_ready),
    .r1_addr       (r1_addr),
    .r1_wdata      (r1_wdata),
    .r1_read_req   (r1_read_req),
    .r1_write_req  (r1_write_req),
    .r1_rdata      (r1_rdata),
    .r1_ready      (r1_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read_req  (mem_read_req),
    .mem_write_req (mem_write_req),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic first_of_pair();
`ifdef ARB_RR_EN
    return rr_model;
`else
    return 1'b1;
`endif
  endfunction

  task automatic push_read(input logic port, input logic [31:0] addr);
    mem_exp_t  m;
    resp_exp_t r;
    m.wr = 1'b0; m.addr = addr; m.wdata = 32'h0;
    r.port = port; r.rdata = {16{addr}};
    exp_mem.push_back(m);
    exp_resp.push_back(r);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((busy !== 1'b0 || exp_resp.size() != 0) && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 512'(n < 60), 512'(1));
    chk({tag, "_mem_q_empty"}, 512'(exp_mem.size()), 512'(0));
    chk({tag, "_resp_q_empty"}, 512'(exp_resp.size()), 512'(0));
  endtask

  // Memory model: completes each request MEM_LAT cycles after the request pulse.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    resp_cnt  = 0;
    resp_addr = 32'h0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          mem_ready = 1'b1;
          mem_rdata = use_fixed ? fixed_line : {16{resp_addr}};
        end
      end
      if (mem_read_req || mem_write_req) begin
        resp_cnt  = MEM_LAT;
        resp_addr = mem_addr;
      end
    end
  end

  // Scoreboard monitor: pops expectations as the DUT produces requests and responses.
  initial begin
    mem_exp_t  m;
    resp_exp_t r;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_read_req || mem_write_req) begin
          chk("mem_req_expected", 512'(exp_mem.size() > 0), 512'(1));
          chk("mem_req_onehot", 512'(mem_read_req & mem_write_req), 512'(0));
          if (exp_mem.size() > 0) begin
            m = exp_mem.pop_front();
            chk("mem_op_write", 512'(mem_write_req), 512'(m.wr));
            chk("mem_addr", 512'(mem_addr), 512'(m.addr));
            if (m.wr) chk("mem_wdata", 512'(mem_wdata), 512'(m.wdata));
          end
        end
        if (r0_ready || r1_ready) begin
          chk("resp_expected", 512'(exp_resp.size() > 0), 512'(1));
          chk("resp_onehot", 512'(r0_ready & r1_ready), 512'(0));
          if (exp_resp.size() > 0) begin
            r = exp_resp.pop_front();
            chk("resp_port", 512'(r1_ready), 512'(r.port));
            chk("resp_rdata", r.port ? r1_rdata : r0_rdata, r.rdata);
            rr_model = ~r.port;
          end
        end
      end
    end
  end

  initial begin
    mem_exp_t     m;
    resp_exp_t    r;
    logic         first;
    logic [511:0] prev;

    rst_n = 1'b0;
    r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0;
    r0_read_req = 0; r0_write_req = 0; r1_read_req = 0; r1_write_req = 0;
    use_fixed = 1'b0; fixed_line = '0; rr_model = 1'b0;
    step();
    step();
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_proto_err", 512'(proto_err), 512'(0));
    chk("rst_mem_req", 512'({mem_read_req, mem_write_req}), 512'(0));
    chk("rst_mem_addr", 512'(mem_addr), 512'(0));
    chk("rst_ready", 512'({r0_ready, r1_ready}), 512'(0));
    chk("rst_r0_rdata", r0_rdata, 512'(0));
    rst_n = 1'b1;
    step();

    // Port 0 read with exact latency checks.
    use_fixed = 1'b1;
    fixed_line = {64{8'hA5}};
    m.wr = 1'b0; m.addr = 32'h0000_1040; m.wdata = 32'h0;
    r.port = 1'b0; r.rdata = {64{8'hA5}};
    exp_mem.push_back(m);
    exp_resp.push_back(r);
    r0_addr = 32'h0000_1040; r0_read_req = 1'b1;
    step();
    r0_read_req = 1'b0;
    chk("t1_busy", 512'(busy), 512'(1));
    chk("t1_req_t1", 512'(mem_read_req), 512'(0));
    step();
    chk("t1_req_t2", 512'(mem_read_req), 512'(1));
    chk("t1_addr_t2", 512'(mem_addr), 512'(32'h0000_1040));
    step();
    chk("t1_req_t3", 512'(mem_read_req), 512'(0));
    chk("t1_addr_hold", 512'(mem_addr), 512'(32'h0000_1040));
    step();
    chk("t1_ready_t4", 512'({r0_ready, r1_ready}), 512'(0));
    step();
    chk("t1_ready_t5", 512'({r0_ready, r1_ready}), 512'(0));
    step();
    chk("t1_r0_ready_t6", 512'(r0_ready), 512'(1));
    chk("t1_r1_ready_t6", 512'(r1_ready), 512'(0));
    step();
    chk("t1_r0_rdata", r0_rdata, {64{8'hA5}});
    chk("t1_ready_t7", 512'(r0_ready), 512'(0));
    wait_idle("t1");
    use_fixed = 1'b0;

    // Two simultaneous pairs of reads.
    for (int p = 0; p < 2; p++) begin
      first = first_of_pair();
      if (first) begin
        push_read(1'b1, 32'h200); push_read(1'b0, 32'h100);
      end else begin
        push_read(1'b0, 32'h100); push_read(1'b1, 32'h200);
      end
      r0_addr = 32'h100; r1_addr = 32'h200;
      r0_read_req = 1'b1; r1_read_req = 1'b1;
      step();
      r0_read_req = 1'b0; r1_read_req = 1'b0;
      wait_idle("t2_pair");
      chk("t2_r0_rdata", r0_rdata, {16{32'h100}});
      chk("t2_r1_rdata", r1_rdata, {16{32'h200}});
    end

    // Port 0 write: response pulse, line unchanged.
    prev = r0_rdata;
    m.wr = 1'b1; m.addr = 32'h0000_2004; m.wdata = 32'hDEAD_BEEF;
    r.port = 1'b0; r.rdata = prev;
    exp_mem.push_back(m);
    exp_resp.push_back(r);
    r0_addr = 32'h0000_2004; r0_wdata = 32'hDEAD_BEEF; r0_write_req = 1'b1;
    step();
    r0_write_req = 1'b0;
    wait_idle("t3");
    chk("t3_r0_rdata_kept", r0_rdata, prev);
    chk("t3_proto_err", 512'(proto_err), 512'(0));

    // Second pulse on port 1 while pending.
    push_read(1'b1, 32'h300);
    r1_addr = 32'h300; r1_read_req = 1'b1;
    step();
    chk("t4_err_before", 512'(proto_err), 512'(0));
    r1_addr = 32'h304;
    step();
    r1_read_req = 1'b0;
    chk("t4_err_set", 512'(proto_err), 512'(1));
    chk("t4_issue_addr", 512'(mem_addr), 512'(32'h300));
    wait_idle("t4");
    chk("t4_err_sticky", 512'(proto_err), 512'(1));
    chk("t4_r1_rdata", r1_rdata, {16{32'h300}});

    // Reset during WAIT, late mem_ready afterwards.
    m.wr = 1'b0; m.addr = 32'h400; m.wdata = 32'h0;
    exp_mem.push_back(m);
    r0_addr = 32'h400; r0_read_req = 1'b1;
    step();
    r0_read_req = 1'b0;
    step();
    chk("t5_issue", 512'(mem_read_req), 512'(1));
    step();
    rst_n = 1'b0;
    rr_model = 1'b0;
    #1;
    chk("t5_rst_busy", 512'(busy), 512'(0));
    chk("t5_rst_mem_addr", 512'(mem_addr), 512'(0));
    chk("t5_rst_proto_err", 512'(proto_err), 512'(0));
    chk("t5_rst_r0_rdata", r0_rdata, 512'(0));
    chk("t5_rst_r1_rdata", r1_rdata, 512'(0));
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_no_ready", 512'({r0_ready, r1_ready}), 512'(0));
      chk("t5_no_mem_req", 512'({mem_read_req, mem_write_req}), 512'(0));
      chk("t5_idle", 512'(busy), 512'(0));
    end
    chk("t5_r0_rdata_zero", r0_rdata, 512'(0));
    chk("t5_mem_q_empty", 512'(exp_mem.size()), 512'(0));

    // Port 0 re-requests in the cycle of its own r0_ready.
    push_read(1'b0, 32'h500);
    r0_addr = 32'h500; r0_read_req = 1'b1;
    step();
    r0_read_req = 1'b0;
    step();
    chk("t6_req_a", 512'(mem_read_req), 512'(1));
    for (int i = 0; i < 4; i++) step();
    chk("t6_ready", 512'(r0_ready), 512'(1));
    push_read(1'b0, 32'h540);
    r0_addr = 32'h540; r0_read_req = 1'b1;
    step();
    r0_read_req = 1'b0;
    chk("t6_no_err", 512'(proto_err), 512'(0));
    chk("t6_req_gap", 512'(mem_read_req), 512'(0));
    step();
    chk("t6_req_b", 512'(mem_read_req), 512'(1));
    chk("t6_addr_b", 512'(mem_addr), 512'(32'h540));
    wait_idle("t6");
    chk("t6_r0_rdata", r0_rdata, {16{32'h540}});

    // Read and write on one port in the same cycle: dropped with an error.
    r0_addr = 32'h600; r0_read_req = 1'b1; r0_write_req = 1'b1;
    step();
    r0_read_req = 1'b0; r0_write_req = 1'b0;
    chk("t7_err", 512'(proto_err), 512'(1));
    chk("t7_not_busy", 512'(busy), 512'(0));
    step();
    step();
    chk("t7_no_mem_req", 512'({mem_read_req, mem_write_req}), 512'(0));
    wait_idle("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
